// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave round-robin arbiter for the native
// valid/ready memory bus. Master 0 is the CPU core, master 1 the loader/DMA.
// A grant covers exactly one transaction and ends on slave ready. At least one
// idle cycle separates transactions, so s_valid always drops after s_ready.
//
// Ports:
//   clk, reset              - rising-edge clock, asynchronous active-high reset
//   m0_* / m1_*             - master request (valid, instr, addr, wdata, wstrb)
//                             and response (ready pulse, rdata)
//   s_*                     - forwarded request to the address decoder and its
//                             ready/rdata response
//   grant                   - one-hot owner, 00 when idle
//   bus_err                 - sticky watchdog flag
//
// Optional feature: define MEM_BUS_ARBITER_TIMEOUT_EN to build a watchdog that
// completes a stalled transaction after TIMEOUT busy cycles with ERR_RDATA.
// Without it, bus_err is tied to 0 and a stalled slave hangs the owner.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy0 = 2'd1,
        StBusy1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;   // 0: master 0 wins contention, 1: master 1 wins
    logic        owner;            // selected master while busy
    logic        cur_valid;
    logic        cur_ready;
    logic [31:0] cur_rdata;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt_q;
    logic        bus_err_q;
    logic        timeout_hit;
`endif

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        owner     = (state_q == StBusy1);
        cur_valid = 1'b0;
        cur_ready = 1'b0;
        cur_rdata = '0;
        s_valid   = 1'b0;
        s_instr   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m0_ready  = 1'b0;
        m0_rdata  = '0;
        m1_ready  = 1'b0;
        m1_rdata  = '0;
        grant     = 2'b00;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (m0_valid && m1_valid) begin
                    state_d = prio_q ? StBusy1 : StBusy0;
                end else if (m0_valid) begin
                    state_d = StBusy0;
                end else if (m1_valid) begin
                    state_d = StBusy1;
                end
            end
            StBusy0, StBusy1: begin
                grant     = owner ? 2'b10 : 2'b01;
                cur_valid = owner ? m1_valid : m0_valid;
                s_valid   = cur_valid;
                s_instr   = owner ? m1_instr : m0_instr;
                s_addr    = owner ? m1_addr  : m0_addr;
                s_wdata   = owner ? m1_wdata : m0_wdata;
                s_wstrb   = owner ? m1_wstrb : m0_wstrb;
                cur_ready = s_ready;
                cur_rdata = s_rdata;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                // A real ready on the last cycle wins over the watchdog.
                if (!s_ready && cur_valid && (tmo_cnt_q == TmoLast)) begin
                    timeout_hit = 1'b1;
                    s_valid     = 1'b0;
                    cur_ready   = 1'b1;
                    cur_rdata   = ERR_RDATA;
                end
`endif
                if (cur_ready) begin
                    state_d = StIdle;
                    prio_d  = ~owner;
                end else if (!cur_valid) begin
                    // Abandoned request: release the bus without touching prio.
                    state_d = StIdle;
                end
                if (owner) begin
                    m1_ready = cur_ready;
                    m1_rdata = cur_rdata;
                end else begin
                    m0_ready = cur_ready;
                    m0_rdata = cur_rdata;
                end
            end
            default: state_d = StIdle;
        endcase

        // Keep the slave quiet for the whole reset pulse, not just after the edge.
        if (reset) begin
            s_valid  = 1'b0;
            s_instr  = 1'b0;
            s_addr   = '0;
            s_wdata  = '0;
            s_wstrb  = '0;
            m0_ready = 1'b0;
            m0_rdata = '0;
            m1_ready = 1'b0;
            m1_rdata = '0;
            grant    = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Every busy period is preceded by an idle cycle, which clears the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                tmo_cnt_q <= '0;
            end else if (!s_ready) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change 2 ns after the rising edge,
// outputs are sampled 1 ns later, well clear of the next edge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT  (8),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_valid(m0_valid),
        .m0_instr(m0_instr),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready),
        .m0_rdata(m0_rdata),
        .m1_valid(m1_valid),
        .m1_instr(m1_instr),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready),
        .m1_rdata(m1_rdata),
        .s_valid (s_valid),
        .s_instr (s_instr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .grant   (grant),
        .bus_err (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready  = 0; s_rdata  = 0;

        // Reset state, with a request pending to prove outputs stay forced.
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_instr = 1;
        tick();
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        m0_valid = 0; m0_instr = 0;
        tick();
        reset = 1'b0;

        // Single master read: s_valid one cycle after request, ready 2 cycles later.
        tick();
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 0;
        #1;
        check("t1_idle_s_valid", 32'(s_valid), 32'h0);
        tick();
        #1;
        check("t1_s_valid", 32'(s_valid), 32'h1);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_s_addr", s_addr, 32'h0000_0010);
        check("t1_m0_ready_wait", 32'(m0_ready), 32'h0);
        tick();
        #1;
        check("t1_m0_ready_wait2", 32'(m0_ready), 32'h0);
        tick();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        check("t1_m0_ready", 32'(m0_ready), 32'h1);
        check("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        check("t1_m1_ready", 32'(m1_ready), 32'h0);
        tick();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        #1;
        check("t1_grant_idle", 32'(grant), 32'h0);
        check("t1_m0_ready_after", 32'(m0_ready), 32'h0);
        check("t1_s_valid_after", 32'(s_valid), 32'h0);

        // Simultaneous requests from reset: m0 first, then m1 write.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 0;
        m1_valid = 1; m1_addr = 32'h0300_0000; m1_wstrb = 4'hF; m1_wdata = 32'h0000_00A5;
        tick();
        #1;
        check("t2_grant_first", 32'(grant), 32'h1);
        check("t2_s_addr_first", s_addr, 32'h0000_0100);
        s_ready = 1; s_rdata = 32'h0000_0B0B;
        #1;
        check("t2_m0_ready", 32'(m0_ready), 32'h1);
        check("t2_m1_ready_low", 32'(m1_ready), 32'h0);
        tick();
        m0_valid = 0; s_ready = 0;
        #1;
        check("t2_gap_grant", 32'(grant), 32'h0);
        tick();
        #1;
        check("t2_grant_second", 32'(grant), 32'h2);
        check("t2_s_wstrb", 32'(s_wstrb), 32'hF);
        check("t2_s_wdata", s_wdata, 32'h0000_00A5);
        check("t2_s_addr", s_addr, 32'h0300_0000);
        s_ready = 1;
        #1;
        check("t2_m1_ready", 32'(m1_ready), 32'h1);
        check("t2_m0_ready_low", 32'(m0_ready), 32'h0);
        check("t2_m0_rdata_zero", m0_rdata, 32'h0);
        tick();
        m1_valid = 0; s_ready = 0;

        // Round-robin: both request continuously, slave always ready.
        tick();
        m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h0000_0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr%0d_idle", i), 32'(grant), 32'h0);
            tick();
            #1;
            check($sformatf("rr%0d_grant", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr%0d_both_ready", i), 32'(m0_ready & m1_ready), 32'h0);
            tick();
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;

        // Reset mid-transaction: m0 done first so prio points at m1, then abort BUSY1.
        tick();
        m0_valid = 1;
        tick();
        s_ready = 1;
        tick();
        m0_valid = 0; s_ready = 0; m1_valid = 1;
        tick();
        #1;
        check("t4_busy1", 32'(grant), 32'h2);
        check("t4_s_valid_busy", 32'(s_valid), 32'h1);
        reset = 1;
        #1;
        check("t4_rst_s_valid", 32'(s_valid), 32'h0);
        check("t4_rst_grant", 32'(grant), 32'h0);
        check("t4_rst_m1_ready", 32'(m1_ready), 32'h0);
        tick();
        reset = 0; m0_valid = 1; m1_valid = 1;
        tick();
        #1;
        check("t4_m0_wins", 32'(grant), 32'h1);
        s_ready = 1;
        tick();
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick();

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        // Watchdog: slave never answers, 8th busy cycle completes with error data.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0500_0000; m0_wstrb = 0;
        tick();
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c < 8) begin
                check($sformatf("to_wait%0d", c), 32'(m0_ready), 32'h0);
            end else begin
                check("to_m0_ready", 32'(m0_ready), 32'h1);
                check("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
                check("to_s_valid", 32'(s_valid), 32'h0);
            end
            tick();
        end
        m0_valid = 0;
        #1;
        check("to_bus_err", 32'(bus_err), 32'h1);
        check("to_grant_idle", 32'(grant), 32'h0);
        m1_valid = 1; m1_addr = 32'h0000_0200;
        tick();
        s_ready = 1; s_rdata = 32'h0000_0077;
        #1;
        check("to_m1_ready", 32'(m1_ready), 32'h1);
        check("to_m1_rdata", m1_rdata, 32'h0000_0077);
        tick();
        m1_valid = 0; s_ready = 0;
        #1;
        check("to_bus_err_sticky", 32'(bus_err), 32'h1);

        // Boundary: real ready exactly on the 8th cycle is a normal completion.
        do_reset();
        #1;
        check("tb_bus_err_cleared", 32'(bus_err), 32'h0);
        m0_valid = 1;
        tick();
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        s_ready = 1; s_rdata = 32'h0000_0055;
        #1;
        check("tb_m0_ready", 32'(m0_ready), 32'h1);
        check("tb_m0_rdata", m0_rdata, 32'h0000_0055);
        tick();
        m0_valid = 0; s_ready = 0;
        #1;
        check("tb_bus_err", 32'(bus_err), 32'h0);
`else
        // Without the watchdog a stalled slave keeps the owner waiting.
        do_reset();
        m0_valid = 1; m0_addr = 32'h0500_0000;
        tick();
        for (int c = 1; c <= 12; c++) begin
            tick();
        end
        #1;
        check("nt_still_busy", 32'(grant), 32'h1);
        check("nt_no_ready", 32'(m0_ready), 32'h0);
        check("nt_bus_err", 32'(bus_err), 32'h0);
        m0_valid = 0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
